lag_elastic_channel: RTL

- Parametrised pipelined inter-router channel carrying `nPC` independent physical channels per trunk.
- Each stage is a 2-entry elastic buffer with a valid/ready handshake, so downstream back-pressure propagates without flit loss.
- Sits between router output ports and neighbour input ports; supersedes the plain register channel when links need flow control.
- Adds a synchronous flush and a per-PC occupancy count.

---
 rtl/lag_channel_pkg.sv | 27 ++
 rtl/lag_elastic_buf.sv | 91 +++++++++
 rtl/lag_elastic_channel.sv | 88 ++++++++
 3 files changed

// File: rtl/lag_channel_pkg.sv
// ============================================================================
// lag_channel_pkg : shared types and helpers for the elastic inter-router channel
// Revision: 1.0
// ============================================================================
`default_nettype none

package lag_channel_pkg;

  localparam int DW_DEFAULT = 64;

  typedef logic [DW_DEFAULT-1:0] flit_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } stage_state_e;

  // Each stage holds at most two flits, so a PC never exceeds 2*stages.
  function automatic int occ_width(input int stages);
    if (stages < 1) return 1;
    return $clog2(2 * stages + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lag_elastic_buf.sv
// ============================================================================
// lag_elastic_buf : one 2-entry (main + skid) elastic stage for a single PC
// Revision: 1.0
// ============================================================================
`default_nettype none

module lag_elastic_buf
  import lag_channel_pkg::*;
#(
  parameter int dw = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [dw-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [dw-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready
);

  stage_state_e  state;
  logic [dw-1:0] main_data;
  logic [dw-1:0] skid_data;
  logic          valid_reg;
  logic          ready_reg;
  logic          accept;
  logic          drain;

  assign accept    = in_valid & ready_reg;
  assign drain     = valid_reg & out_ready;
  assign in_ready  = ready_reg;
  assign out_valid = valid_reg;
  assign out_data  = main_data;

  // Main is cleared whenever it empties so out_data reads zero while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      skid_data <= '0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else if (flush) begin
      state     <= EMPTY;
      main_data <= '0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= in_data;
            valid_reg <= 1'b1;
            state     <= FULL1;
          end
        end
        FULL1: begin
          if (accept && !drain) begin
            skid_data <= in_data;
            ready_reg <= 1'b0;
            state     <= FULL2;
          end else if (drain && !accept) begin
            main_data <= '0;
            valid_reg <= 1'b0;
            state     <= EMPTY;
          end else if (accept && drain) begin
            main_data <= in_data;
          end
        end
        FULL2: begin
          if (drain) begin
            main_data <= skid_data;
            ready_reg <= 1'b1;
            state     <= FULL1;
          end
        end
        default: begin
          state     <= EMPTY;
          main_data <= '0;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/lag_elastic_channel.sv
// ============================================================================
// lag_elastic_channel : pipelined elastic channel, stages x nPC buffers with
//                       per-PC occupancy counters and synchronous flush
// Revision: 1.0
// ============================================================================
`default_nettype none

module lag_elastic_channel
  import lag_channel_pkg::*;
#(
  parameter int stages = 1,
  parameter int nPC    = 1,
  parameter int dw     = DW_DEFAULT
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      flush,
  input  logic [nPC-1:0][dw-1:0]                    in_data,
  input  logic [nPC-1:0]                            in_valid,
  output logic [nPC-1:0]                            in_ready,
  output logic [nPC-1:0][dw-1:0]                    out_data,
  output logic [nPC-1:0]                            out_valid,
  input  logic [nPC-1:0]                            out_ready,
  output logic [nPC-1:0][occ_width(stages)-1:0]     occupancy
);

  localparam int OW = occ_width(stages);

  generate
    if (stages == 0) begin : g_pass
      assign out_data  = in_data;
      assign out_valid = in_valid;
      assign in_ready  = out_ready;
      assign occupancy = '0;

      logic unused_ctrl;
      assign unused_ctrl = ^{clk, rst, flush};
    end else begin : g_pipe
      for (genvar p = 0; p < nPC; p++) begin : g_pc
        logic [stages:0][dw-1:0] d;
        logic [stages:0]         v;
        logic [stages:0]         r;
        logic [OW-1:0]           occ;
        logic                    acc;
        logic                    drn;

        assign d[0]         = in_data[p];
        assign v[0]         = in_valid[p];
        assign in_ready[p]  = r[0];
        assign out_data[p]  = d[stages];
        assign out_valid[p] = v[stages];
        assign r[stages]    = out_ready[p];

        for (genvar s = 0; s < stages; s++) begin : g_stage
          lag_elastic_buf #(.dw(dw)) u_buf (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .in_data   (d[s]),
            .in_valid  (v[s]),
            .in_ready  (r[s]),
            .out_data  (d[s+1]),
            .out_valid (v[s+1]),
            .out_ready (r[s+1])
          );
        end

        assign acc = v[0] & r[0];
        assign drn = v[stages] & r[stages];

        always_ff @(posedge clk) begin
          if (rst || flush) begin
            occ <= '0;
          end else if (acc && !drn) begin
            occ <= occ + OW'(1);
          end else if (drn && !acc) begin
            occ <= occ - OW'(1);
          end
        end

        assign occupancy[p] = occ;
      end
    end
  endgenerate

endmodule

`default_nettype wire
